// File: rtl/l2_block_memory.sv
// ============================================================================
// Module   : l2_block_memory
// Summary  : Block-granular L2 backing store with fixed-latency fills and
//            writebacks, stall output and saturating access counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module l2_block_memory #(
  parameter int BLOCKS = 4,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [31:0]            mem_read_addr,
  input  logic [31:0]            mem_write_addr,
  input  logic [BLOCKS*32-1:0]   mem_write_block,
  output logic [BLOCKS*32-1:0]   mem_read_block,
  output logic                   mem_miss,
  output logic [31:0]            rd_cnt,
  output logic [31:0]            wr_cnt
);

  localparam int BW     = BLOCKS * 32;
  localparam int OFFSET = $clog2(BLOCKS * 4);
  localparam int IDXW   = $clog2(DEPTH);
  localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int LW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  localparam logic [LW-1:0] c_RD_INIT = LW'(RD_LAT - 1);
  localparam logic [LW-1:0] c_WR_INIT = LW'(WR_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [LW-1:0]     r_lat_cnt;
  logic [IDXW-1:0]   r_rd_idx;
  logic [IDXW-1:0]   r_wr_idx;
  logic [BW-1:0]     r_wr_blk;
  logic [BW-1:0]     r_rd_blk;
  logic [31:0]       r_rd_cnt;
  logic [31:0]       r_wr_cnt;
  logic [BW-1:0]     r_mem [DEPTH];

  logic [IDXW-1:0]   w_rd_idx;
  logic [IDXW-1:0]   w_wr_idx;
  logic              w_unused_addr;

  // Offset and upper address bits are dropped; upper-bit aliasing is intended.
  assign w_rd_idx      = mem_read_addr[OFFSET +: IDXW];
  assign w_wr_idx      = mem_write_addr[OFFSET +: IDXW];
  assign w_unused_addr = ^{mem_read_addr, mem_write_addr};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_rd_idx  <= '0;
      r_wr_idx  <= '0;
      r_wr_blk  <= '0;
      r_rd_blk  <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (mem_req) begin
            r_rd_idx <= w_rd_idx;
            r_wr_idx <= w_wr_idx;
            r_wr_blk <= mem_write_block;
            if (mem_we) begin
              r_state   <= S_WRITE;
              r_lat_cnt <= c_WR_INIT;
            end else begin
              r_state   <= S_READ;
              r_lat_cnt <= c_RD_INIT;
            end
          end
        end
        S_WRITE: begin
          if (r_lat_cnt == '0) begin
            r_mem[r_wr_idx] <= r_wr_blk;
            if (r_wr_cnt != 32'hFFFF_FFFF) begin
              r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            r_state   <= S_READ;
            r_lat_cnt <= c_RD_INIT;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_READ: begin
          // Write commits an earlier edge, so a same-index fill sees new data.
          if (r_lat_cnt == '0) begin
            r_rd_blk <= r_mem[r_rd_idx];
            if (r_rd_cnt != 32'hFFFF_FFFF) begin
              r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            r_state <= S_DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_miss = 1'b0;
    unique case (r_state)
      S_IDLE:  mem_miss = mem_req & reset;
      S_WRITE: mem_miss = 1'b1;
      S_READ:  mem_miss = 1'b1;
      S_DONE:  mem_miss = 1'b0;
      default: mem_miss = 1'b0;
    endcase
  end

  assign mem_read_block = r_rd_blk;
  assign rd_cnt         = r_rd_cnt;
  assign wr_cnt         = r_wr_cnt;

endmodule

`default_nettype wire
